// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction memory loader: FSM state
// encoding and the fixed frame geometry (bytes per word, header count width).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_WIDTH    = 16;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// loader_byte_packer
// Assembles big-endian 32-bit words from a byte stream and keeps the 8-bit
// running sum of every shifted byte.
//
// Ports:
//   clock        system clock
//   reset        synchronous active-low reset
//   i_clear      synchronous clear (load restart)
//   i_shift      accept i_byte this cycle
//   i_byte       stream byte
//   o_word_next  word as it will be once i_byte is shifted in
//   o_sum        running sum of accepted bytes, mod 256
//   o_word_full  this shift completes a word (4th byte)
// -----------------------------------------------------------------------------
module loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_next,
    output logic [7:0]  o_sum,
    output logic        o_word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [7:0]  r_sum;

    // The first byte of a word ends up in [31:24] after three more shifts.
    assign o_word_next = {r_word[23:0], i_byte};
    assign o_sum       = r_sum;
    assign o_word_full = i_shift && (r_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_sum  <= '0;
        end else if (i_shift) begin
            r_word <= o_word_next;
            r_idx  <= r_idx + 2'd1;
            r_sum  <= r_sum + i_byte;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the imem write port. Receives a framed byte stream
// (16-bit word count, 4*N data bytes MSB first, 8-bit additive checksum),
// writes the words to imem addresses 0..N-1 and releases the processor reset
// once the checksum matches.
//
// Ports:
//   clock, reset         system clock, synchronous active-low reset
//   start                restart pulse, honoured only in DONE / ERR
//   in_byte/in_valid/in_ready   byte stream handshake
//   imem_wEn/imem_addr/imem_dataIn   imem write port (one-cycle wEn per word)
//   cpu_reset            held high until a load completes cleanly
//   done / error         load status
//   words_loaded         words written in the current/last load
//
// state  | meaning
// HDR_HI | waiting for word count high byte
// HDR_LO | waiting for word count low byte
// DATA   | collecting the bytes of the next word
// WRITE  | single-cycle imem write of the assembled word
// CHK    | waiting for checksum byte
// DONE   | load good, processor released
// ERR    | oversize count or bad checksum
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_wEn,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_dataIn,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH:0]    r_words;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;

    logic                   w_accept;
    logic                   w_restart;
    logic                   w_shift;
    logic [31:0]            w_word_next;
    logic [7:0]             w_sum;
    logic                   w_word_full;
    logic [COUNT_WIDTH-1:0] w_count_full;
    logic [ADDR_WIDTH:0]    w_words_inc;
    logic                   w_oversize;
    logic                   w_last_word;

    assign w_accept     = in_valid && in_ready;
    assign w_restart    = start && ((r_state == DONE) || (r_state == ERR));
    assign w_shift      = w_accept && (r_state == DATA);
    assign w_count_full = {r_count[15:8], in_byte};
    assign w_words_inc  = r_words + 1'b1;
    // Compared in 32 bits so the capacity 2^ADDR_WIDTH itself is representable.
    assign w_oversize   = 32'(w_count_full) > (32'd1 << ADDR_WIDTH);
    assign w_last_word  = 32'(w_words_inc) == 32'(r_count);

    loader_byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_restart),
        .i_shift     (w_shift),
        .i_byte      (in_byte),
        .o_word_next (w_word_next),
        .o_sum       (w_sum),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            HDR_HI: if (w_accept) w_state_next = HDR_LO;
            HDR_LO: begin
                if (w_accept) begin
                    if (w_oversize)              w_state_next = ERR;
                    else if (w_count_full == '0) w_state_next = CHK;
                    else                         w_state_next = DATA;
                end
            end
            DATA:   if (w_word_full) w_state_next = WRITE;
            WRITE:  w_state_next = w_last_word ? CHK : DATA;
            CHK: begin
                if (w_accept) w_state_next = (in_byte == w_sum) ? DONE : ERR;
            end
            DONE:   if (start) w_state_next = HDR_HI;
            ERR:    if (start) w_state_next = HDR_HI;
            default: w_state_next = HDR_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_restart) begin
                r_words <= '0;
            end
            if (w_accept && (r_state == HDR_HI)) begin
                r_count[15:8] <= in_byte;
            end
            if (w_accept && (r_state == HDR_LO)) begin
                r_count[7:0] <= in_byte;
            end
            // Address and data are latched as the word completes so they are
            // already valid during the WRITE cycle, then simply held.
            if (w_word_full) begin
                r_addr <= r_words[ADDR_WIDTH-1:0];
                r_data <= DATA_WIDTH'(w_word_next);
            end
            if (r_state == WRITE) begin
                r_words <= w_words_inc;
            end
        end
    end

    assign in_ready     = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                          (r_state == DATA)   || (r_state == CHK);
    assign imem_wEn     = (r_state == WRITE);
    assign imem_addr    = r_addr;
    assign imem_dataIn  = r_data;
    assign done         = (r_state == DONE);
    assign error        = (r_state == ERR);
    assign cpu_reset    = (r_state != DONE);
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW  = 12;
    localparam int CAP = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          imem_wEn;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_dataIn;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks   = 0;
    int failures = 0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] fw[$];
    logic        prev_wen = 1'b0;

    always #5 clock = ~clock;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_wEn     (imem_wEn),
        .imem_addr    (imem_addr),
        .imem_dataIn  (imem_dataIn),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write pulse is matched against the model queue.
    initial begin
        forever begin
            @(negedge clock);
            if (imem_wEn === 1'b1) begin
                if (prev_wen) begin
                    failures++;
                    $display("FAIL wen_pulse: got two-cycle wEn at addr %0h expected single cycle", imem_addr);
                end
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got write %0h@%0h expected none", imem_dataIn, imem_addr);
                end else begin
                    check("write_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
                    check("write_data", 64'(imem_dataIn), 64'(exp_data.pop_front()));
                end
            end
            prev_wen = imem_wEn;
        end
    end

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
        end
        in_byte  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                @(negedge clock);
                in_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    endtask

    // Reference model: frame built from fw, checksum = byte sum mod 256 + delta.
    task automatic run_frame(input int n, input logic [7:0] chk_delta, input bit stall);
        logic [7:0] sum = 8'd0;
        bit         oversize = (n > CAP);
        bit         ok;
        int         waited = 0;
        send_byte(8'((n >> 8) & 255), stall);
        send_byte(8'(n & 255), stall);
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(fw[i]);
                for (int k = 3; k >= 0; k--) begin
                    logic [7:0] b;
                    b = 8'((fw[i] >> (8 * k)) & 32'hFF);
                    sum = sum + b;
                    send_byte(b, stall);
                end
            end
            send_byte(sum + chk_delta, stall);
        end
        ok = !oversize && (chk_delta == 8'd0);
        while (!(done || error) && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("frame_done", 64'(done), 64'(ok));
        check("frame_error", 64'(error), 64'(!ok));
        check("frame_cpu_reset", 64'(cpu_reset), 64'(!ok));
        check("frame_words_loaded", 64'(words_loaded), oversize ? 64'd0 : 64'(n));
        check("frame_in_ready", 64'(in_ready), 64'd0);
        check("frame_pending_writes", 64'(exp_data.size()), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_done", 64'(done), 64'd0);
        check("start_error", 64'(error), 64'd0);
        check("start_cpu_reset", 64'(cpu_reset), 64'd1);
        check("start_words_loaded", 64'(words_loaded), 64'd0);
        check("start_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wen", 64'(imem_wEn), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_data", 64'(imem_dataIn), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Two-word frame, good checksum, in_valid held.
        fw = '{32'hDEADBEEF, 32'h00000013};
        run_frame(2, 8'd0, 1'b0);
        pulse_start();

        // Same frame, checksum off by one.
        run_frame(2, 8'd1, 1'b0);
        pulse_start();

        // Empty frame.
        fw = {};
        run_frame(0, 8'd0, 1'b0);
        pulse_start();

        // Oversize count: 4097 words.
        run_frame(CAP + 1, 8'd0, 1'b0);
        in_byte  = 8'h55;
        in_valid = 1'b1;
        repeat (5) @(negedge clock);
        check("err_hold_in_ready", 64'(in_ready), 64'd0);
        check("err_hold_error", 64'(error), 64'd1);
        in_valid = 1'b0;
        pulse_start();

        // Reset after two data bytes of word 0; partial word must never be written.
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_words_loaded", 64'(words_loaded), 64'd0);
        check("midrst_data", 64'(imem_dataIn), 64'd0);
        check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        fw = '{32'h12345678};
        run_frame(1, 8'd0, 1'b0);

        // Random words with random in_valid stalls, then a restart.
        pulse_start();
        fw = {};
        for (int i = 0; i < 3; i++) fw.push_back($urandom);
        run_frame(3, 8'd0, 1'b1);
        pulse_start();
        fw = {};
        fw.push_back($urandom);
        run_frame(1, 8'd0, 1'b1);

        // Full capacity load.
        pulse_start();
        fw = {};
        for (int i = 0; i < CAP; i++) fw.push_back($urandom);
        run_frame(CAP, 8'd0, 1'b0);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
